// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the pipelined ARM32 core.
//
// It holds the 7-bit program counter and drives a synchronous-read
// instruction memory. Each returned word is registered, together with its PC,
// into the fetch/decode pipeline register that feeds the decoder.
//
// The stage also handles three control cases:
//   - a downstream stall (the in-flight address is replayed so no word is lost),
//   - a branch redirect, which inserts two NOP bubbles,
//   - PC wrap-around from 7'h7F to 7'h00.
//
// Ports:
//   clk           in   1   single clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   stall_f       in   1   hold fetch stage and outputs this cycle
//   branch_valid  in   1   redirect request (beats stall)
//   branch_target in   7   redirect PC (word address)
//   imem_addr     out  7   instruction memory read address
//   imem_rdata    in  32   read data, one cycle after the address
//   pc_out        out  7   PC of instr_out (decoder pc_in)
//   instr_out     out 32   fetched instruction (decoder instr_in)
//   valid_out     out  1   1 = real instruction, 0 = bubble
//   stall_cnt     out 16   saturating stall-cycle counter
//
// Optional feature macro FETCH_STALL_CNT_EN:
//   - when defined, the stall-cycle counter is built;
//   - otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        branch_valid,
   input  logic [6:0]  branch_target,
   output logic [6:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [6:0]  pc_out,
   output logic [31:0] instr_out,
   output logic        valid_out,
   output logic [15:0] stall_cnt
);

   // FILL: no request in flight (after reset or redirect); RUN: req_pc is live
   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [6:0]  fetch_pc_q, fetch_pc_d;
   logic [6:0]  req_pc_q, req_pc_d;
   logic [6:0]  pc_out_q, pc_out_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic        valid_out_q, valid_out_d;
   logic        req_valid;

   // Modulo-128 increment: 7'h7F wraps to 7'h00 by truncation
   function automatic logic [6:0] pc_inc(input logic [6:0] pc);
      return pc + 7'd1;
   endfunction

   assign req_valid = (state_q == RUN);

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      pc_out_d    = pc_out_q;
      instr_out_d = instr_out_q;
      valid_out_d = valid_out_q;

      // While stalled, re-present the in-flight address so that imem_rdata
      // still carries that word on the cycle the stall releases.
      imem_addr = (stall_f && !branch_valid) ? req_pc_q : fetch_pc_q;

      if (branch_valid) begin
         // Redirect squashes the in-flight request; pc_out intentionally holds
         fetch_pc_d  = branch_target;
         state_d     = FILL;
         valid_out_d = 1'b0;
         instr_out_d = NOP_INSTR;
      end else if (!stall_f) begin
         req_pc_d    = fetch_pc_q;
         state_d     = RUN;
         fetch_pc_d  = pc_inc(fetch_pc_q);
         pc_out_d    = req_pc_q;
         instr_out_d = req_valid ? imem_rdata : NOP_INSTR;
         valid_out_d = req_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FILL;
         fetch_pc_q  <= 7'd0;
         req_pc_q    <= 7'd0;
         pc_out_q    <= 7'd0;
         instr_out_q <= NOP_INSTR;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         pc_out_q    <= pc_out_d;
         instr_out_q <= instr_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign pc_out    = pc_out_q;
   assign instr_out = instr_out_q;
   assign valid_out = valid_out_q;

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Only genuine stalls count; a redirect overrides the stall on that edge
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && !branch_valid) begin
         stall_cnt_d = sat_inc16(stall_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined ARM32 core, directly upstream of the decode stage. Holds the 7-bit program counter, drives a synchronous-read instruction memory, and registers each returned word with its PC into the fetch/decode pipeline register that feeds the decoder's `pc_in`/`instr_in`. Handles the downstream stall, branch redirect with bubble (NOP) insertion, and PC wrap-around.

## Interface
Parameters:
- `NOP_INSTR`, default 32'hE1A00000 (MOV r0,r0): word driven on `instr_out` for bubbles and reset.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `stall_f`  input  1  hold fetch stage and outputs this cycle.
- `branch_valid`  input  1  redirect request from a later stage.
- `branch_target`  input  7  redirect PC (word address).
- `imem_addr`  output  7  instruction memory read address.
- `imem_rdata`  input  32  read data; returns mem[addr presented in cycle N] during cycle N+1.
- `pc_out`  output  7  PC of `instr_out`; feeds decoder `pc_in`.
- `instr_out`  output  32  fetched instruction; feeds decoder `instr_in`.
- `valid_out`  output  1  1 = real instruction, 0 = bubble.
- `stall_cnt`  output  16  stall-cycle count (see Configuration).

## Operation
- Internal registers: `fetch_pc` (address being requested), `req_pc`/`req_valid` (request in flight, data arrives this cycle), output registers.
- `imem_addr` = `req_pc` when `stall_f`=1 and no redirect (replay in-flight address so `imem_rdata` still holds it next cycle); otherwise `fetch_pc`.
- Normal cycle (no stall, no redirect): `req_pc`<=`fetch_pc`, `req_valid`<=1, `fetch_pc`<=`fetch_pc`+1, outputs <= {`req_pc`, `imem_rdata`, `req_valid`}; if `req_valid`=0, `instr_out`<=NOP_INSTR.
- Stall (`stall_f`=1, `branch_valid`=0): `fetch_pc`, `req_pc`, `req_valid`, outputs all hold.
- Redirect (`branch_valid`=1, regardless of `stall_f`): `fetch_pc`<=`branch_target`, `req_valid`<=0, `valid_out`<=0, `instr_out`<=NOP_INSTR, `pc_out` holds. Redirect beats stall.
- Arithmetic: `fetch_pc`+1 is modulo 128; 7'h7F wraps to 7'h00, no flag.
- Effective state: FILL (`req_valid`=0, after reset or redirect) -> RUN on next non-stalled edge; RUN -> FILL on redirect; RUN/FILL hold on stall.

## Timing
- Reset (edge with `rst_n`=0): `fetch_pc`=0, `req_pc`=0, `req_valid`=0, `pc_out`=0, `instr_out`=NOP_INSTR, `valid_out`=0, `stall_cnt`=0. `stall_f`/`branch_valid` ignored. Reset mid-stream discards in-flight request.
- After reset: first edge with `rst_n`=1 (E0) issues PC 0; `pc_out`=0 with `valid_out`=1 after E1; then one instruction per cycle.
- Fetch latency: address presented cycle N -> on outputs after edge ending N+1.
- Redirect asserted cycle N: bubbles after edges N and N+1; `pc_out`=`branch_target`, `valid_out`=1 after edge N+2 (2-cycle penalty).
- Stall: outputs frozen the cycle `stall_f` is high; on release the held in-flight word is delivered on the next edge, no loss, no duplicate.
- Redirect during stall: takes effect same edge; stall has no effect on redirect timing.

## Configuration
- `FETCH_STALL_CNT_EN` defined: `stall_cnt` increments on every non-reset edge with `stall_f`=1 and `branch_valid`=0; saturates at 16'hFFFF; cleared only by reset.
- Undefined: counter not built; `stall_cnt` tied to 16'h0000. No other behaviour changes.

## Test plan
- Reset then run, mem[i]=32'hE0000000+i: after E1 `pc_out`=0/`instr_out`=E0000000; after E4 `pc_out`=3, `valid_out`=1 each cycle.
- Wrap: `branch_target`=7'h7E, run 4 cycles: `pc_out` sequence 7E,7F,00,01, all valid.
- Stall 3 cycles while `pc_out`=5: outputs hold 5 for 3 cycles, then 6,7 consecutively; no skipped/duplicated PC; with `FETCH_STALL_CNT_EN`, `stall_cnt`=3.
- Redirect to 0x40 at cycle N while streaming: two bubbles (`valid_out`=0, `instr_out`=E1A00000), then `pc_out`=40, 41.
- `branch_valid` and `stall_f` both high, target 0x10: redirect wins; `pc_out`=10 valid two edges later; `stall_cnt` unchanged.
- Assert `rst_n`=0 for one edge mid-stream (and mid-stall): all outputs return to reset values; restart from PC 0 as in first scenario.
